cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the team's fixed 16-bit four-group CLA adder. The operand width is split into NG = WIDTH/GROUP lookahead groups, with one group per pipeline stage and the group carry registered between stages. A valid/ready handshake on both sides lets the block sit between datapath producers and consumers that can stall. It also adds subtract mode, signed overflow detection and optional saturation.

---
 rtl/cla_pipe_adder.sv | 182 ++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, valid/ready on both sides.
// Optional signed saturation of S on overflow when CLA_PIPE_SAT_EN is defined.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic                     Cin,
    input  logic                     SUB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         S,
    output logic                     Cout,
    output logic                     V,
    output logic [WIDTH/GROUP-1:0]   P,
    output logic [WIDTH/GROUP-1:0]   G
);
    localparam int NG = WIDTH / GROUP;

    logic adv;

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_stage
            localparam int LO = gi * GROUP;
            localparam int HI = LO + GROUP;

            logic [WIDTH-1:LO] opa;
            logic [WIDTH-1:LO] opb;
            logic              c_in;
            logic              vld_in;
            logic [NG-1:0]     p_in;
            logic [NG-1:0]     g_in;
            logic [NG-1:0]     p_next;
            logic [NG-1:0]     g_next;
            logic [GROUP-1:0]  ga;
            logic [GROUP-1:0]  gb;
            logic [GROUP-1:0]  gp;
            logic [GROUP-1:0]  gg;
            logic [GROUP-1:0]  gx;
            logic [GROUP:0]    gc;
            logic              grp_p;
            logic              grp_g;
            logic [HI-1:0]     s_cat;
            logic [HI-1:0]     s_next;
            logic              valid_reg;
            logic              c_reg;
            logic [NG-1:0]     p_reg;
            logic [NG-1:0]     g_reg;
            logic [HI-1:0]     s_reg;

            if (gi == 0) begin : g_src
                assign opa    = A;
                assign opb    = SUB ? ~B : B;
                assign c_in   = SUB | Cin;
                assign vld_in = in_valid;
                assign p_in   = '0;
                assign g_in   = '0;
                assign s_cat  = gx ^ gc[GROUP-1:0];
            end else begin : g_chain
                assign opa    = g_stage[gi-1].g_fwd.a_reg;
                assign opb    = g_stage[gi-1].g_fwd.b_reg;
                assign c_in   = g_stage[gi-1].c_reg;
                assign vld_in = g_stage[gi-1].valid_reg;
                assign p_in   = g_stage[gi-1].p_reg;
                assign g_in   = g_stage[gi-1].g_reg;
                assign s_cat  = {gx ^ gc[GROUP-1:0], g_stage[gi-1].s_reg};
            end

            // Propagate is the inclusive form (a|b) so the reported group P reads as "carry passes through".
            assign ga = opa[LO +: GROUP];
            assign gb = opb[LO +: GROUP];
            assign gp = ga | gb;
            assign gg = ga & gb;
            assign gx = ga ^ gb;

            // Each carry is a flat sum of products over the group, not a ripple chain.
            always_comb begin : la
                logic term;
                term  = 1'b0;
                gc    = '0;
                grp_g = 1'b0;
                gc[0] = c_in;
                for (int i = 0; i < GROUP; i++) begin
                    term = c_in;
                    for (int m = 0; m <= i; m++) term = term & gp[m];
                    gc[i+1] = term;
                    for (int j = 0; j <= i; j++) begin
                        term = gg[j];
                        for (int m = j + 1; m <= i; m++) term = term & gp[m];
                        gc[i+1] = gc[i+1] | term;
                    end
                end
                for (int j = 0; j < GROUP; j++) begin
                    term = gg[j];
                    for (int m = j + 1; m < GROUP; m++) term = term & gp[m];
                    grp_g = grp_g | term;
                end
            end

            assign grp_p = &gp;

            always_comb begin
                p_next     = p_in;
                g_next     = g_in;
                p_next[gi] = grp_p;
                g_next[gi] = grp_g;
            end

            if (gi < NG - 1) begin : g_fwd
                logic [WIDTH-1:HI] a_reg;
                logic [WIDTH-1:HI] b_reg;

                assign s_next = s_cat;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (adv) begin
                        a_reg <= opa[WIDTH-1:HI];
                        b_reg <= opb[WIDTH-1:HI];
                    end
                end
            end else begin : g_out
                logic v_next;
                logic v_reg;

                assign v_next = gc[GROUP] ^ gc[GROUP-1];
`ifdef CLA_PIPE_SAT_EN
                // On overflow both effective operands share a sign, which is the sign of the true result.
                always_comb begin
                    s_next = s_cat;
                    if (v_next)
                        s_next = ga[GROUP-1] ? {1'b1, {(HI-1){1'b0}}} : {1'b0, {(HI-1){1'b1}}};
                end
`else
                assign s_next = s_cat;
`endif
                always_ff @(posedge clk) begin
                    if (rst)
                        v_reg <= 1'b0;
                    else if (adv)
                        v_reg <= v_next;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    c_reg     <= 1'b0;
                    p_reg     <= '0;
                    g_reg     <= '0;
                    s_reg     <= '0;
                end else if (adv) begin
                    valid_reg <= vld_in;
                    c_reg     <= gc[GROUP];
                    p_reg     <= p_next;
                    g_reg     <= g_next;
                    s_reg     <= s_next;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[NG-1].valid_reg;
    assign S         = g_stage[NG-1].s_reg;
    assign Cout      = g_stage[NG-1].c_reg;
    assign V         = g_stage[NG-1].g_out.v_reg;
    assign P         = g_stage[NG-1].p_reg;
    assign G         = g_stage[NG-1].g_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed test-plan vectors, a random stalled stream against an arithmetic
// reference model, mid-flight reset, and a 32-bit/8-bit-group instance.
module tb_cla_pipe_adder;
    localparam int W  = 16;
    localparam int GR = 4;
    localparam int NG = W / GR;
    localparam int EW = W + 2 + 2 * NG;

`ifdef CLA_PIPE_SAT_EN
    localparam logic [W-1:0]  S_OVF_POS = 16'h7FFF;
    localparam logic [W-1:0]  S_OVF_NEG = 16'h8000;
    localparam logic [31:0]   S32_EXP   = 32'h8000_0000;
`else
    localparam logic [W-1:0]  S_OVF_POS = 16'h8000;
    localparam logic [W-1:0]  S_OVF_NEG = 16'h0000;
    localparam logic [31:0]   S32_EXP   = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, s;
    logic          cin, sub, cout, v;
    logic [NG-1:0] p, g;

    logic          in_valid32, in_ready32, out_valid32, out_ready32, cout32, v32;
    logic [31:0]   a32, b32, s32;
    logic          cin32, sub32;
    logic [3:0]    p32, g32;

    cla_pipe_adder #(.WIDTH(W), .GROUP(GR)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .SUB(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .Cout(cout), .V(v), .P(p), .G(g)
    );

    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a32), .B(b32), .Cin(cin32), .SUB(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .S(s32), .Cout(cout32), .V(v32), .P(p32), .G(g32)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_ready = 1'b0;
    bit lat_chk    = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, req, cyc);
        end
    endtask

    // Reference: plain integer addition for S/Cout, sign rule for V, per-group OR/add-carry for P/G.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mcin, input logic msub);
        logic [W-1:0]  be, ms;
        logic [W:0]    full;
        logic          mv;
        logic [NG-1:0] mp, mg;
        logic [GR-1:0] ag, bg;
        logic [GR:0]   gs;
        be   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (msub | mcin)};
        ms   = full[W-1:0];
        mv   = (ma[W-1] == be[W-1]) && (ms[W-1] != ma[W-1]);
`ifdef CLA_PIPE_SAT_EN
        if (mv) ms = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        for (int k = 0; k < NG; k++) begin
            ag    = ma[k*GR +: GR];
            bg    = be[k*GR +: GR];
            mp[k] = &(ag | bg);
            gs    = {1'b0, ag} + {1'b0, bg};
            mg[k] = gs[GR];
        end
        return {ms, full[W], mv, mp, mg};
    endfunction

    // Drive one beat and hold it until the DUT takes it; the expectation is queued at acceptance.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, input logic [EW-1:0] e);
        bit done = 1'b0;
        in_valid = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: retire in order, check latency when no stalls are injected, and check output hold during stalls.
    logic [EW:0] held;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            t;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) check("stall_hold", 64'({out_valid, s, cout, v, p, g}), 64'(held));
            held_v = out_valid && !out_ready;
            held   = {out_valid, s, cout, v, p, g};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("result", 64'({s, cout, v, p, g}), 64'(e));
                    if (lat_chk) check("latency", 64'(cyc - t), 64'(NG));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   r;
        logic [W-1:0]  ra, rb;
        int            n;
        logic [W-1:0]  d_a[5], d_b[5];
        logic          d_cin[5], d_sub[5];
        logic [EW-1:0] d_exp[5];

        d_a[0] = 16'h1234; d_b[0] = 16'h4321; d_cin[0] = 1'b1; d_sub[0] = 1'b0;
        d_exp[0] = {16'h5556, 1'b0, 1'b0, 4'b0000, 4'b0000};
        d_a[1] = 16'hFFFF; d_b[1] = 16'h0001; d_cin[1] = 1'b0; d_sub[1] = 1'b0;
        d_exp[1] = {16'h0000, 1'b1, 1'b0, 4'b1111, 4'b0001};
        d_a[2] = 16'h7FFF; d_b[2] = 16'hFFFF; d_cin[2] = 1'b0; d_sub[2] = 1'b1;
        d_exp[2] = {S_OVF_POS, 1'b0, 1'b1, 4'b0111, 4'b0000};
        d_a[3] = 16'h8000; d_b[3] = 16'h8000; d_cin[3] = 1'b0; d_sub[3] = 1'b0;
        d_exp[3] = {S_OVF_NEG, 1'b1, 1'b1, 4'b0000, 4'b1000};
        d_a[4] = 16'h0000; d_b[4] = 16'h0000; d_cin[4] = 1'b0; d_sub[4] = 1'b1;
        d_exp[4] = {16'h0000, 1'b1, 1'b0, 4'b1111, 4'b0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({out_valid, s, cout, v, p, g}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // 32-bit, 8-bit groups: both operands at the most negative value.
        @(posedge clk); #1;
        in_valid32 = 1'b1; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
        @(negedge clk);
        check("accept32", 64'(in_ready32), 64'(1));
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            @(negedge clk);
            if (out_valid32) n = i;
        end
        check("latency32", 64'(n), 64'(4));
        check("result32", 64'({s32, cout32, v32, p32, g32}), 64'({S32_EXP, 1'b1, 1'b1, 4'b0000, 4'b1000}));
        @(negedge clk);
        check("pulse32", 64'(out_valid32), 64'(0));

        // Directed test-plan vectors, back to back, no stalls.
        @(posedge clk); #1;
        lat_chk = 1'b1;
        for (int k = 0; k < 5; k++) send(d_a[k], d_b[k], d_cin[k], d_sub[k], d_exp[k]);
        repeat (2) begin @(posedge clk); #1; end
        drain("drain_directed");

        // Random stream with out_ready toggling and occasional input bubbles.
        @(posedge clk); #1;
        lat_chk = 1'b0;
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r = $urandom; ra = r[W-1:0];
            r = $urandom; rb = r[W-1:0];
            r = $urandom;
            send(ra, rb, r[0], r[1], model(ra, rb, r[0], r[1]));
            if (r[5:4] == 2'b00) begin @(posedge clk); #1; end
        end
        rand_ready = 1'b0;
        drain("drain_random");

        // Reset with three beats in flight, then one clean beat.
        @(posedge clk); #1;
        lat_chk = 1'b1;
        for (int k = 0; k < 3; k++) send(16'h1111 * 16'(k + 1), 16'h0F0F, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", 64'({out_valid, s}), 64'(0));
        @(posedge clk); #1;
        send(16'hABCD, 16'h1234, 1'b1, 1'b1, model(16'hABCD, 16'h1234, 1'b1, 1'b1));
        drain("drain_after_reset");
        repeat (NG + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
